// File: rtl/patternbuf_ctrl.sv
// patternbuf_ctrl: serial pattern buffer with a validated frame commit and a registered field-read port.
// Define PATBUF_DBLBUF_EN to shift into a shadow array that is copied atomically to the active array.
module patternbuf_ctrl #(
  parameter int BUF_WIDTH  = 8,
  parameter int BUF_SIZE   = 32,
  parameter int PTR_W      = $clog2(BUF_SIZE),
  parameter int FRAME_BITS = BUF_WIDTH*BUF_SIZE
) (
  input  logic                 sclk,
  input  logic                 rst_n,
  input  logic                 ssel,
  input  logic                 sin,
  output logic                 sout,
  input  logic [PTR_W-1:0]     fieldp,
  input  logic                 field_rd,
  output logic [BUF_WIDTH-1:0] field_byte,
  output logic                 field_vld,
  output logic                 load_done,
  output logic                 load_err,
  output logic                 loaded
);
  localparam int CNT_W = $clog2(FRAME_BITS+2);
  localparam int N = BUF_WIDTH*BUF_SIZE;
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_END} state_t;
  state_t state;
  logic [CNT_W-1:0] cnt;
  logic [N-1:0] act;
  logic [BUF_WIDTH-1:0] rd_word;
  logic good;
  // Words are stored flat; one left shift of the whole vector carries MSBs into the next word.
  assign good = cnt == CNT_W'(FRAME_BITS);
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < BUF_SIZE; i++)
      if (fieldp == PTR_W'(i)) rd_word = act[i*BUF_WIDTH +: BUF_WIDTH];
  end
`ifdef PATBUF_DBLBUF_EN
  logic [N-1:0] shd;
  assign sout = shd[N-1];
  always_ff @(posedge sclk or negedge rst_n)
    if (!rst_n) shd <= '0;
    else if (ssel) shd <= {shd[N-2:0], sin};
`else
  assign sout = act[N-1];
`endif
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      act        <= '0;
      loaded     <= 1'b0;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
      field_byte <= '0;
      field_vld  <= 1'b0;
    end else begin
      load_done <= 1'b0;
      load_err  <= 1'b0;
      field_vld <= field_rd;
      if (field_rd) field_byte <= rd_word;
      case (state)
        S_IDLE, S_END: begin
          state <= ssel ? S_SHIFT : S_IDLE;
          if (ssel) cnt <= CNT_W'(1);
`ifndef PATBUF_DBLBUF_EN
          if (ssel) loaded <= 1'b0;
`endif
        end
        S_SHIFT: begin
          if (ssel) begin
            if (cnt != CNT_W'(FRAME_BITS+1)) cnt <= cnt + CNT_W'(1);
          end else begin
            state     <= S_END;
            load_done <= good;
            load_err  <= !good;
            if (good) loaded <= 1'b1;
`ifdef PATBUF_DBLBUF_EN
            if (good) act <= shd;
`endif
          end
        end
        default: state <= S_IDLE;
      endcase
`ifndef PATBUF_DBLBUF_EN
      if (ssel) act <= {act[N-2:0], sin};
`endif
    end
  end
endmodule

// File: tb/tb_patternbuf_ctrl.sv
// tb_patternbuf_ctrl: randomized frames and reads checked against a bit-history reference model.
module tb_patternbuf_ctrl;
`ifdef PATBUF_DBLBUF_EN
  localparam bit DBL = 1'b1;
`else
  localparam bit DBL = 1'b0;
`endif
  logic sclk = 1'b0, rst_n = 1'b0, ssel = 1'b0, sin = 1'b0, field_rd = 1'b0;
  logic [5:0] fieldp = '0;
  logic sout, field_vld, load_done, load_err, loaded;
  logic [7:0] field_byte;
  int n_chk = 0, n_fail = 0;
  bit act_q[$], shd_q[$], fr[$];
  bit in_frame, m_loaded, e_vld, e_done, e_err;
  int nb;
  logic [7:0] e_byte;

  patternbuf_ctrl #(.PTR_W(6)) dut (
    .sclk(sclk), .rst_n(rst_n), .ssel(ssel), .sin(sin), .sout(sout),
    .fieldp(fieldp), .field_rd(field_rd), .field_byte(field_byte),
    .field_vld(field_vld), .load_done(load_done), .load_err(load_err), .loaded(loaded)
  );

  always #5 sclk = ~sclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Queues hold bit history, most recent bit first; word k bit j is history position 8k+j.
  function automatic logic [7:0] word(input int k);
    logic [7:0] w;
    for (int j = 0; j < 8; j++) w[j] = act_q[8*k+j];
    return w;
  endfunction

  task automatic model_reset();
    act_q = {}; shd_q = {};
    for (int i = 0; i < 256; i++) begin act_q.push_back(1'b0); shd_q.push_back(1'b0); end
    in_frame = 0; m_loaded = 0; e_vld = 0; e_done = 0; e_err = 0; e_byte = 0; nb = 0;
  endtask

  task automatic model(input bit s, input bit b, input bit r, input int p);
    e_vld = r; e_done = 0; e_err = 0;
    if (r) e_byte = p < 32 ? word(p) : 8'h00;
    if (s) begin
      if (!in_frame) begin
        in_frame = 1; nb = 0;
        if (!DBL) m_loaded = 0;
      end
      nb++;
      if (DBL) begin shd_q.push_front(b); void'(shd_q.pop_back()); end
      else begin act_q.push_front(b); void'(act_q.pop_back()); end
    end else if (in_frame) begin
      in_frame = 0;
      e_done = nb == 256;
      e_err = !e_done;
      if (e_done) begin
        m_loaded = 1;
        if (DBL) act_q = shd_q;
      end
    end
  endtask

  task automatic check_all();
    chk("field_vld", field_vld, e_vld);
    chk("field_byte", field_byte, e_byte);
    chk("load_done", load_done, e_done);
    chk("load_err", load_err, e_err);
    chk("loaded", loaded, m_loaded);
    chk("sout", sout, DBL ? shd_q[255] : act_q[255]);
  endtask

  task automatic step(input bit s, input bit b, input bit r, input int p);
    ssel = s; sin = b; field_rd = r; fieldp = 6'(p);
    @(posedge sclk);
    model(s, b, r, p);
    #1;
    check_all();
  endtask

  task automatic mk(input int len);
    fr = {};
    for (int i = 0; i < len; i++) fr.push_back(1'($urandom));
  endtask

  // p < 0 picks random read addresses (including out-of-range ones).
  task automatic send(input int len, input int p);
    for (int i = 0; i < len; i++)
      step(1'b1, fr[i], ($urandom % 4) == 0, p < 0 ? int'($urandom % 41) : p);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, ($urandom % 2) == 0, int'($urandom % 41));
  endtask

  initial begin
    logic [7:0] first, a5;
    model_reset();
    #12;
    check_all();
    @(negedge sclk) rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b1, 5);
    chk("rd5_after_reset", field_byte, 8'h00);
    // Full frame ending in 0xA5
    mk(256);
    a5 = 8'hA5;
    for (int j = 0; j < 8; j++) fr[248+j] = a5[7-j];
    for (int j = 0; j < 8; j++) first[7-j] = fr[j];
    send(256, -1);
    step(1'b0, 1'b0, 1'b0, 0);
    chk("done_full_frame", load_done, 1'b1);
    step(1'b0, 1'b0, 1'b1, 0);
    chk("word0_a5", field_byte, 8'hA5);
    step(1'b0, 1'b0, 1'b1, 31);
    chk("word31_first", field_byte, first);
    // Short and long frames are rejected
    mk(255); send(255, -1); idle(2);
    mk(300); send(300, -1); idle(2);
    chk("loaded_after_err", loaded, DBL);
    // Reads during a shift and around the commit edge
    mk(256); send(256, 3);
    step(1'b0, 1'b0, 1'b1, 3);
    step(1'b0, 1'b0, 1'b1, 3);
    // Back-to-back reads, in and out of range
    step(1'b0, 1'b0, 1'b1, 31);
    step(1'b0, 1'b0, 1'b1, 40);
    chk("rd40_zero", field_byte, 8'h00);
    chk("rd40_vld", field_vld, 1'b1);
    // Reset in the middle of a frame
    mk(256); send(100, -1);
    rst_n = 1'b0;
    model_reset();
    #2;
    check_all();
    @(negedge sclk) rst_n = 1'b1;
    mk(256); send(256, -1);
    chk("sout_first_bit", sout, fr[0]);
    step(1'b0, 1'b0, 1'b0, 0);
    chk("done_after_reset", load_done, 1'b1);
    // Random frames, including back-to-back with a single idle cycle
    for (int f = 0; f < 16; f++) begin
      int len;
      len = ($urandom % 3) != 0 ? 256 : int'($urandom_range(1, 300));
      mk(len); send(len, -1);
      idle(int'($urandom_range(1, 3)));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
